// File: rtl/sprite_scheduler.sv
// Frame sequencer for the sprite path: queues draw commands, then runs one
// clear pass, blits every queued sprite in order and swaps buffers on vsync.
module sprite_scheduler #(
   parameter int DEPTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   input  logic [1:0]              cmd_sprite_num_i,
   input  logic [9:0]              cmd_x_i,
   input  logic [9:0]              cmd_y_i,
   output logic                    cmd_ready_o,
   input  logic                    frame_go_i,
   input  logic                    frame_ack_i,
   output logic                    frame_done_o,
   output logic                    busy_o,
   output logic                    clear_start_o,
   input  logic                    clear_done_i,
   output logic                    blit_start_o,
   output logic [1:0]              blit_sprite_num_o,
   output logic [9:0]              blit_x_o,
   output logic [9:0]              blit_y_o,
   input  logic                    blitter_finished_i,
   input  logic                    vsync_i,
   output logic                    fb_sel_o,
   output logic [$clog2(DEPTH):0]  sprites_drawn_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_CLEAR_WAIT,
      S_ISSUE,
      S_BLIT_WAIT,
      S_SWAP_WAIT,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [1:0] sprite_num;
      logic [9:0] x;
      logic [9:0] y;
   } cmd_t;

   state_e         state_q, state_d;
   cmd_t           mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   cmd_t           blit_q;
   logic           vsync_q;
   logic           fb_sel_q;
   logic [CW-1:0]  drawn_q;

   logic           wr_en;
   logic           pop;
   logic           vsync_rise;
   logic           queue_nonempty;

   assign cmd_ready_o    = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
   assign wr_en          = cmd_valid_i && cmd_ready_o;
   assign queue_nonempty = (count_q != '0);
   assign vsync_rise     = vsync_i && !vsync_q;
   // The head is popped on the transition into ISSUE, so it is already in blit_q.
   assign pop            = (state_d == S_ISSUE);

   always_comb begin
      // NOTE: next state defaults to the current state so no path infers a latch.
      state_d = state_q;
      case (state_q)
         S_IDLE:       if (frame_go_i) state_d = S_CLEAR;
         S_CLEAR:      state_d = S_CLEAR_WAIT;
         S_CLEAR_WAIT: if (clear_done_i) state_d = queue_nonempty ? S_ISSUE : S_SWAP_WAIT;
         S_ISSUE:      state_d = S_BLIT_WAIT;
         S_BLIT_WAIT:  if (blitter_finished_i) state_d = queue_nonempty ? S_ISSUE : S_SWAP_WAIT;
         S_SWAP_WAIT:  if (vsync_rise) state_d = S_DONE;
         S_DONE:       if (frame_ack_i) state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         blit_q   <= '0;
         vsync_q  <= 1'b0;
         fb_sel_q <= 1'b0;
         drawn_q  <= '0;
      end else begin
         state_q <= state_d;
         vsync_q <= vsync_i;

         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            blit_q   <= mem_q[rd_ptr_q];
         end
         // Writes happen only in IDLE and pops only while rendering.
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         if (state_q == S_IDLE && frame_go_i) begin
            drawn_q <= '0;
         end else if (state_q == S_BLIT_WAIT && blitter_finished_i) begin
            drawn_q <= drawn_q + 1'b1;
         end

         if (state_q == S_SWAP_WAIT && vsync_rise) fb_sel_q <= ~fb_sel_q;
      end
   end

   // NOTE: the command storage is not reset; emptiness is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= '{sprite_num: cmd_sprite_num_i, x: cmd_x_i, y: cmd_y_i};
   end

   assign busy_o            = (state_q != S_IDLE);
   assign clear_start_o     = (state_q == S_CLEAR);
   assign blit_start_o      = (state_q == S_ISSUE);
   assign frame_done_o      = (state_q == S_DONE);
   assign blit_sprite_num_o = blit_q.sprite_num;
   assign blit_x_o          = blit_q.x;
   assign blit_y_o          = blit_q.y;
   assign fb_sel_o          = fb_sel_q;
   assign sprites_drawn_o   = drawn_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: expected blits and frame results are
// queued at stimulus time and checked by an independent output monitor.
module tb_sprite_scheduler;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [1:0] num;
      logic [9:0] x;
      logic [9:0] y;
   } cmd_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_sprite_num;
   logic [9:0] cmd_x, cmd_y;
   logic       cmd_ready;
   logic       frame_go, frame_ack, frame_done, busy;
   logic       clear_start, clear_done;
   logic       blit_start;
   logic [1:0] blit_sprite_num;
   logic [9:0] blit_x, blit_y;
   logic       blitter_finished;
   logic       vsync;
   logic       fb_sel;
   logic [3:0] sprites_drawn;

   int         checks = 0;
   int         errors = 0;
   int         model_count = 0;
   logic       model_fb = 1'b0;
   cmd_t       exp_blit [$];
   logic [4:0] exp_frame [$];

   always #5 clk = ~clk;

   sprite_scheduler #(.DEPTH(DEPTH)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .cmd_valid_i        (cmd_valid),
      .cmd_sprite_num_i   (cmd_sprite_num),
      .cmd_x_i            (cmd_x),
      .cmd_y_i            (cmd_y),
      .cmd_ready_o        (cmd_ready),
      .frame_go_i         (frame_go),
      .frame_ack_i        (frame_ack),
      .frame_done_o       (frame_done),
      .busy_o             (busy),
      .clear_start_o      (clear_start),
      .clear_done_i       (clear_done),
      .blit_start_o       (blit_start),
      .blit_sprite_num_o  (blit_sprite_num),
      .blit_x_o           (blit_x),
      .blit_y_o           (blit_y),
      .blitter_finished_i (blitter_finished),
      .vsync_i            (vsync),
      .fb_sel_o           (fb_sel),
      .sprites_drawn_o    (sprites_drawn)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Monitor: every blit_start and every frame_done rise consumes one expectation.
   cmd_t       mon_cmd;
   logic [4:0] mon_frame;
   logic       prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (blit_start) begin
            if (exp_blit.size() == 0) begin
               fail_now("blit_unexpected");
            end else begin
               mon_cmd = exp_blit.pop_front();
               check("blit_cmd", {blit_sprite_num, blit_x, blit_y}, mon_cmd);
            end
         end
         if (frame_done && !prev_done) begin
            if (exp_frame.size() == 0) begin
               fail_now("frame_unexpected");
            end else begin
               mon_frame = exp_frame.pop_front();
               check("frame_result", {fb_sel, sprites_drawn}, mon_frame);
            end
         end
         prev_done = frame_done;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_ctl"}, {busy, cmd_ready, frame_done, clear_start, blit_start, fb_sel}, 6'b010000);
      check({name, "_blit"}, {blit_sprite_num, blit_x, blit_y}, 22'd0);
      check({name, "_drawn"}, sprites_drawn, 4'd0);
   endtask

   task automatic write_cmd(input logic [1:0] n, input logic [9:0] x, input logic [9:0] y);
      logic exp_rdy;
      cmd_valid = 1'b1;
      cmd_sprite_num = n;
      cmd_x = x;
      cmd_y = y;
      exp_rdy = (model_count < DEPTH);
      @(negedge clk);
      check("cmd_ready", cmd_ready, exp_rdy);
      if (exp_rdy) begin
         exp_blit.push_back({n, x, y});
         model_count++;
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic start_frame(input int clear_dly);
      logic [3:0] n4;
      n4 = model_count[3:0];
      exp_frame.push_back({~model_fb, n4});
      model_fb = ~model_fb;
      model_count = 0;
      frame_go = 1'b1;
      step();
      frame_go = 1'b0;
      @(negedge clk);
      check("clear_start_latency", {clear_start, busy, cmd_ready}, 3'b110);
      check("drawn_zeroed", sprites_drawn, 4'd0);
      step();
      @(negedge clk);
      check("clear_pulse_width", clear_start, 1'b0);
      repeat (clear_dly) step();
      clear_done = 1'b1;
      step();
      clear_done = 1'b0;
   endtask

   task automatic wait_blit(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (blit_start) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) fail_now("blit_timeout");
   endtask

   // Entered at the drive point of the cycle after blit_start; leaves at the
   // drive point of the cycle after the next blit_start (or in SWAP_WAIT).
   task automatic blit_one(input int dly, input bit noise, input bit more);
      int k;
      k = 1;
      if (noise) begin
         frame_go = 1'b1;
         cmd_valid = 1'b1;
         cmd_sprite_num = 2'd3;
         cmd_x = 10'd1;
         cmd_y = 10'd2;
         @(negedge clk);
         check("ready_while_busy", cmd_ready, 1'b0);
         step();
         frame_go = 1'b0;
         cmd_valid = 1'b0;
         k = 2;
      end
      repeat (dly - k) step();
      blitter_finished = 1'b1;
      step();
      // With noise, finished stays high through the ISSUE cycle, where it must be ignored.
      if (!noise) blitter_finished = 1'b0;
      @(negedge clk);
      if (more) check("blit_gap_latency", blit_start, 1'b1);
      else      check("blit_end", blit_start, 1'b0);
      step();
      blitter_finished = 1'b0;
   endtask

   task automatic swap_and_ack(input bit noise, input int n);
      logic       old_fb;
      logic [3:0] n4;
      old_fb = ~model_fb;
      n4 = n[3:0];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_swap_without_edge", {frame_done, fb_sel}, {1'b0, old_fb});
         step();
      end
      vsync = 1'b0;
      step();
      step();
      vsync = 1'b1;
      @(negedge clk);
      check("no_swap_in_edge_cycle", {frame_done, fb_sel}, {1'b0, old_fb});
      step();
      @(negedge clk);
      check("swap_latency", {frame_done, fb_sel}, {1'b1, model_fb});
      for (int i = 0; i < 3; i++) begin
         if (noise) begin
            frame_go = 1'b1;
            blitter_finished = 1'b1;
         end
         step();
         vsync = 1'b0;
         @(negedge clk);
         check("done_held", {frame_done, busy, cmd_ready, clear_start, blit_start}, 5'b11000);
      end
      step();
      frame_go = 1'b0;
      blitter_finished = 1'b0;
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
      @(negedge clk);
      check("ack_to_idle", {frame_done, busy, cmd_ready, clear_start}, 4'b0010);
      check("drawn_retained", sprites_drawn, n4);
      step();
   endtask

   task automatic render(input int clear_dly, input int blit_dly, input bit vs_high, input bit noise);
      int n;
      bit ok;
      n = model_count;
      if (vs_high) begin
         vsync = 1'b1;
         step();
      end
      start_frame(clear_dly);
      if (n > 0) begin
         wait_blit(ok);
         if (ok) begin
            step();
            for (int i = 0; i < n; i++) blit_one(blit_dly, noise, i < n - 1);
         end
      end
      swap_and_ack(noise, n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      frame_go = 1'b0;
      frame_ack = 1'b0;
      clear_done = 1'b0;
      blitter_finished = 1'b0;
      vsync = 1'b0;
      exp_blit.delete();
      exp_frame.delete();
      model_count = 0;
      model_fb = 1'b0;
      @(negedge clk);
      check_reset_state("reset_async");
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_sprite_num = '0;
      cmd_x = '0;
      cmd_y = '0;
      frame_go = 1'b0;
      frame_ack = 1'b0;
      clear_done = 1'b0;
      blitter_finished = 1'b0;
      vsync = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check_reset_state("reset");
      step();
      rst = 1'b0;
      step();

      // Three sprites with a slow blitter.
      write_cmd(2'd1, 10'd10, 10'd5);
      write_cmd(2'd2, 10'd20, 10'd6);
      write_cmd(2'd3, 10'd30, 10'd7);
      render(2, 3, 1'b0, 1'b0);

      // Fill to DEPTH, ninth attempt refused; pointers start mid-buffer and wrap.
      for (int i = 0; i < 8; i++) write_cmd(2'(i), 10'(100 + i), 10'(200 + i));
      write_cmd(2'd3, 10'd999, 10'd999);
      render(2, 1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) write_cmd(2'(i + 1), 10'(500 + 3 * i), 10'(7 * i));
      // vsync high on entry to SWAP_WAIT, plus ignored frame_go/finished/writes while busy.
      render(1, 2, 1'b1, 1'b1);

      // Empty frame still clears and swaps.
      render(3, 1, 1'b0, 1'b0);

      // Reset during BLIT_WAIT with two sprites still queued.
      write_cmd(2'd0, 10'd40, 10'd50);
      write_cmd(2'd1, 10'd41, 10'd51);
      write_cmd(2'd2, 10'd42, 10'd52);
      start_frame(1);
      wait_blit(ok);
      step();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_after_reset", {busy, cmd_ready, fb_sel, clear_start, blit_start}, 5'b01000);
         step();
      end
      write_cmd(2'd2, 10'd777, 10'd333);
      render(2, 2, 1'b0, 1'b0);

      check("blit_scoreboard_drained", exp_blit.size(), 0);
      check("frame_scoreboard_drained", exp_frame.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
